// File: rtl/hwpe_stream_addressgen_nd.sv
// N-dimensional streamer address generator: walks a loop nest of word lines with signed
// byte strides between lines, emitting word-aligned addresses, byte strobes and end flags.
module hwpe_stream_addressgen_nd #(
    parameter int NB_DIMS = 3,
    parameter int CNT     = 16,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          start_i,
    input  logic [ADDR_W-1:0]             base_addr_i,
    input  logic [NB_DIMS*CNT-1:0]        len_i,
    input  logic [(NB_DIMS-1)*ADDR_W-1:0] stride_i,
    output logic                          addr_valid_o,
    input  logic                          addr_ready_i,
    output logic [ADDR_W-1:0]             addr_o,
    output logic [DATA_W/8-1:0]           strb_o,
    output logic [NB_DIMS-1:0]            dim_last_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT-1:0]    r_len    [NB_DIMS];
    logic [CNT-1:0]    r_cnt    [NB_DIMS];
    logic [ADDR_W-1:0] r_stride [1:NB_DIMS-1];
    logic [ADDR_W-1:0] r_off    [1:NB_DIMS-1];
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [BYTES-1:0]  r_strb;
    logic [NB_DIMS-1:0] r_last;
    logic              r_busy;
    logic              r_done;

    logic [CNT-1:0]    w_in_len    [NB_DIMS];
    logic [ADDR_W-1:0] w_in_stride [1:NB_DIMS-1];
    logic              w_any_zero;
    logic              w_idle;

    genvar gi;
    generate
        for (gi = 0; gi < NB_DIMS; gi++) begin : g_len
            assign w_in_len[gi] = len_i[gi*CNT +: CNT];
        end
        for (gi = 1; gi < NB_DIMS; gi++) begin : g_stride
            assign w_in_stride[gi] = stride_i[(gi-1)*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign w_idle = (r_state == S_IDLE);

    always_comb begin
        w_any_zero = 1'b0;
        for (int d = 0; d < NB_DIMS; d++) begin
            if (w_in_len[d] == '0) w_any_zero = 1'b1;
        end
    end

    // Odometer step from the beat currently presented; r_last[0] marks the last word of a line.
    logic [CNT-1:0]    w_nxt_cnt [NB_DIMS];
    logic [ADDR_W-1:0] w_nxt_off [1:NB_DIMS-1];
    logic              w_found;

    always_comb begin
        w_nxt_cnt = r_cnt;
        w_nxt_off = r_off;
        w_found   = 1'b0;
        if (!r_last[0]) begin
            w_nxt_cnt[0] = r_cnt[0] + 1'b1;
        end else begin
            w_nxt_cnt[0] = '0;
            for (int d = 1; d < NB_DIMS; d++) begin
                if (!w_found) begin
                    if (r_cnt[d] != r_len[d] - 1'b1) begin
                        w_found      = 1'b1;
                        w_nxt_cnt[d] = r_cnt[d] + 1'b1;
                        w_nxt_off[d] = r_off[d] + r_stride[d];
                    end else begin
                        w_nxt_cnt[d] = '0;
                        w_nxt_off[d] = '0;
                    end
                end
            end
        end
    end

    // Beat evaluation: first beat of a fresh job (from the inputs) or the next beat in RUN.
    logic [CNT-1:0]     w_e_len [NB_DIMS];
    logic [CNT-1:0]     w_e_cnt [NB_DIMS];
    logic [ADDR_W-1:0]  w_line;
    logic [OFFW-1:0]    w_lo;
    logic               w_last_word;
    logic [ADDR_W-1:0]  w_e_addr;
    logic [BYTES-1:0]   w_e_strb;
    logic [NB_DIMS-1:0] w_e_last;

    always_comb begin
        w_line = w_idle ? base_addr_i : r_base;
        for (int d = 0; d < NB_DIMS; d++) begin
            w_e_len[d] = w_idle ? w_in_len[d] : r_len[d];
            w_e_cnt[d] = w_idle ? '0 : w_nxt_cnt[d];
        end
        for (int d = 1; d < NB_DIMS; d++) begin
            w_line = w_line + (w_idle ? '0 : w_nxt_off[d]);
        end
        w_lo        = w_line[OFFW-1:0];
        w_last_word = (w_lo == '0) ? (w_e_cnt[0] == w_e_len[0] - 1'b1)
                                   : (w_e_cnt[0] == w_e_len[0]);
        if (w_lo == '0)              w_e_strb = '1;
        else if (w_e_cnt[0] == '0)   w_e_strb = {BYTES{1'b1}} << w_lo;
        else if (w_last_word)        w_e_strb = ~({BYTES{1'b1}} << w_lo);
        else                         w_e_strb = '1;
        w_e_last[0] = w_last_word;
        for (int d = 1; d < NB_DIMS; d++) begin
            w_e_last[d] = w_e_last[d-1] && (w_e_cnt[d] == w_e_len[d] - 1'b1);
        end
        w_e_addr = (w_line & ~ADDR_W'(BYTES-1)) + (ADDR_W'(w_e_cnt[0]) << OFFW);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state <= S_IDLE;
            r_base  <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_strb  <= '0;
            r_last  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int d = 0; d < NB_DIMS; d++) begin
                r_len[d] <= '0;
                r_cnt[d] <= '0;
            end
            for (int d = 1; d < NB_DIMS; d++) begin
                r_stride[d] <= '0;
                r_off[d]    <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_base <= base_addr_i;
                        r_busy <= 1'b1;
                        for (int d = 0; d < NB_DIMS; d++) begin
                            r_len[d] <= w_in_len[d];
                            r_cnt[d] <= '0;
                        end
                        for (int d = 1; d < NB_DIMS; d++) begin
                            r_stride[d] <= w_in_stride[d];
                            r_off[d]    <= '0;
                        end
                        if (w_any_zero) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_valid <= 1'b1;
                            r_addr  <= w_e_addr;
                            r_strb  <= w_e_strb;
                            r_last  <= w_e_last;
                        end
                    end
                end
                S_RUN: begin
                    if (addr_ready_i) begin
                        if (&r_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_addr  <= '0;
                            r_strb  <= '0;
                            r_last  <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt  <= w_nxt_cnt;
                            r_off  <= w_nxt_off;
                            r_addr <= w_e_addr;
                            r_strb <= w_e_strb;
                            r_last <= w_e_last;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign addr_valid_o = r_valid;
    assign addr_o       = r_addr;
    assign strb_o       = r_strb;
    assign dim_last_o   = r_last;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule
